mult_div_ctrl: RTL and testbench
================================

# mult_div_ctrl

Iterative signed multiply/divide sequencer behind the HI/LO registers of the multicycle MIPS core. The main control unit issues a one-cycle `start_mult` or `start_div` (the MULT/DIV states) with rs/rt operand values. The block runs a 32-step shift-add multiply or restoring divide and writes HI/LO. It holds `busy` so the control unit waits before MFHI/MFLO, and reports divide-by-zero to the exception path (EPCWrite sequence).

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are WIDTH each.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately
- `start_mult`  in  1  one-cycle request, signed rs×rt
- `start_div`  in  1  one-cycle request, signed rs÷rt
- `rs_val`  in  WIDTH  operand A (multiplicand / dividend), sampled on the accepting edge only
- `rt_val`  in  WIDTH  operand B (multiplier / divisor), sampled on the accepting edge only
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle completion pulse
- `div_zero`  out  1  one-cycle pulse with `done` on divide by zero
- `hi_out`  out  WIDTH  HI register
- `lo_out`  out  WIDTH  LO register

## Operation
- FSM states: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, FINISH.
- IDLE:
  - `start_mult` → MULT_RUN.
  - `start_div` → DIV_RUN, or FINISH directly when divisor = 0 (trap enabled).
  - Both starts high → multiply wins; `start_div` dropped.
- Starts while `busy` are ignored. No queueing.
- Multiply:
  - Operate on magnitudes: 64-bit accumulator, 5-bit iteration counter, 32 iterations.
  - In FINISH, negate the product if the operand signs differ; {HI,LO} = 64-bit signed product.
- Divide:
  - Restoring division on magnitudes, 32 iterations, then DIV_FIX applies signs.
  - Quotient truncates toward zero (LO). Remainder takes the dividend's sign (HI).
  - 0x80000000 ÷ -1 → LO=0x80000000, HI=0 (no overflow flag).
- FINISH: write HI/LO, pulse `done`, → IDLE.
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi_out`=0, `lo_out`=0, counter=0.
- Reset low mid-operation: abort; HI/LO cleared; no `done`.

## Timing
- E0 = edge accepting a start. `busy` is high from E0 until the completion edge, exclusive.
- Multiply: `done` high in the cycle after edge E0+33; HI/LO valid from that edge.
- Divide: `done` after E0+34 (extra DIV_FIX cycle).
- Divide by zero (trap enabled): `done` and `div_zero` after E0+1.
- A new start is accepted on the edge where `done` is high; back-to-back issue loses no cycle.
- Outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `MULTDIV_DIVZERO_TRAP_EN` defined:
  - Divisor 0 → immediate `done`+`div_zero`; HI/LO unchanged.
- `MULTDIV_DIVZERO_TRAP_EN` undefined:
  - `div_zero` tied 0.
  - Divisor 0 runs the full 34-cycle divide and forces LO=0xFFFFFFFF, HI=rs_val.

## Structure
- Package `mult_div_pkg`: state enum, `MD_ITERS`=32, counter width, sign-fix helper function.
- Sub-module `mult_div_core`: accumulator/remainder registers and shift-add/subtract step, controlled by a step/load/fix interface.
- Top level holds the FSM, counter, handshake and HI/LO registers.

## Test plan
- mult 7 × -3 → `done` after E0+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high exactly 33 cycles.
- mult 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000.
- div -7 ÷ 2 → `done` after E0+34; LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000 ÷ -1 → LO=0x80000000, HI=0.
- div 5 ÷ 0 with trap → `done`=`div_zero`=1 after E0+1; HI/LO keep prior values. Without trap → after E0+34, LO=0xFFFFFFFF, HI=5.
- `start_div` at E0+10 of a multiply → ignored, mult result correct. Both starts at once → multiply result.
- Reset low at E0+10 → `busy`=0, HI=LO=0 immediately; no `done` pulse. Next start after release runs normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
// Optional feature macro: MULTDIV_DIVZERO_TRAP_EN (see mult_div_ctrl).
package mult_div_pkg;

    localparam int MD_W     = 32;
    localparam int MD_ITERS = 32;
    localparam int CNT_W    = $clog2(MD_ITERS);

    typedef enum logic [2:0] {
        IDLE,
        MULT_RUN,
        DIV_RUN,
        DIV_FIX,
        FINISH
    } md_state_e;

    function automatic logic [MD_W-1:0] fix_word(input logic [MD_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*MD_W-1:0] fix_dword(input logic [2*MD_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_core.sv
// Magnitude datapath: shift-add multiply and restoring divide sharing one
// 2*WIDTH accumulator ({HI,LO} for multiply, {remainder,quotient} for divide).
module mult_div_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_W
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] fixed
);

    logic [WIDTH-1:0] opb;
    logic             sa;
    logic             sb;
    logic             div_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        fits    = (shifted >= {1'b0, opb});
    end

    // Zero divisor leaves the all-ones quotient unsigned; the remainder then
    // equals |dividend| and regains the dividend's sign, i.e. HI = rs.
    always_ff @(posedge clk) begin
        if (load) begin
            sa    <= a[WIDTH-1];
            sb    <= b[WIDTH-1];
            div_q <= is_div;
            if (is_div) begin
                opb <= fix_word(b, b[WIDTH-1]);
                acc <= {{WIDTH{1'b0}}, fix_word(a, a[WIDTH-1])};
            end else begin
                opb <= fix_word(a, a[WIDTH-1]);
                acc <= {{WIDTH{1'b0}}, fix_word(b, b[WIDTH-1])};
            end
        end else if (step) begin
            if (div_q) begin
                if (fits) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else      acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {sum, acc[WIDTH-1:1]};
            end
        end else if (fix) begin
            acc <= {fix_word(acc[2*WIDTH-1:WIDTH], sa),
                    fix_word(acc[WIDTH-1:0], (sa ^ sb) & (opb != '0))};
        end
    end

    assign fixed = fix_dword(acc, sa ^ sb);

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide sequencer owning HI/LO.
// Define MULTDIV_DIVZERO_TRAP_EN to finish divide-by-zero at once with div_zero.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    md_state_e          state;
    md_state_e          state_nx;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               op_div;
    logic               dz_pend;
    logic               zero_trap;
    logic               accept_mult;
    logic               accept_div;
    logic               core_load;
    logic               core_step;
    logic               core_fix;
    logic               finish;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] fixed;

`ifdef MULTDIV_DIVZERO_TRAP_EN
    assign zero_trap = (rt_val == '0);
`else
    assign zero_trap = 1'b0;
`endif

    assign last      = (cnt == CNT_W'(MD_ITERS - 1));
    assign core_load = accept_mult | (accept_div & ~zero_trap);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_mult)     state_nx = MULT_RUN;
                else if (start_div) state_nx = zero_trap ? FINISH : DIV_RUN;
            end
            MULT_RUN: if (last) state_nx = FINISH;
            DIV_RUN:  if (last) state_nx = DIV_FIX;
            DIV_FIX:  state_nx = FINISH;
            FINISH:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        accept_mult = 1'b0;
        accept_div  = 1'b0;
        core_step   = 1'b0;
        core_fix    = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                accept_mult = start_mult;
                accept_div  = start_div & ~start_mult;
            end
            MULT_RUN, DIV_RUN: core_step = 1'b1;
            DIV_FIX:           core_fix  = 1'b1;
            FINISH:            finish    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            dz_pend  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= finish;
            div_zero <= finish & dz_pend;
            if (core_load)      cnt <= '0;
            else if (core_step) cnt <= cnt + 1'b1;
            if (accept_mult | accept_div) begin
                busy    <= 1'b1;
                op_div  <= accept_div;
                dz_pend <= accept_div & zero_trap;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

    // Multiply signs are applied on the way into HI/LO; divide already fixed them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (finish && !dz_pend) begin
            {hi_out, lo_out} <= op_div ? acc : fixed;
        end
    end

    mult_div_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .load   (core_load),
        .step   (core_step),
        .fix    (core_fix),
        .is_div (accept_div),
        .a      (rs_val),
        .b      (rt_val),
        .acc    (acc),
        .fixed  (fixed)
    );

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: arithmetic reference model plus directed vectors.
// Honours MULTDIV_DIVZERO_TRAP_EN the same way as the design.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    function automatic res_t model_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic signed [63:0] a64;
        logic signed [63:0] b64;
        logic signed [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        r  = '0;
        sa = a;
        sb = b;
        if (!is_div) begin
            a64 = {{32{a[31]}}, a};
            b64 = {{32{b[31]}}, b};
            p   = a64 * b64;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == 32'd0) begin
`ifdef MULTDIV_DIVZERO_TRAP_EN
            r.dz = 1'b1;
`else
            r.hi = a;
            r.lo = 32'hFFFF_FFFF;
`endif
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.hi = 32'd0;
            r.lo = 32'h8000_0000;
        end else begin
            r.lo = sa / sb;
            r.hi = sa % sb;
        end
        return r;
    endfunction

    function automatic int model_lat(input logic is_div, input logic [31:0] b);
        if (!is_div) return 33;
`ifdef MULTDIV_DIVZERO_TRAP_EN
        if (b == 32'd0) return 1;
`endif
        return 34;
    endfunction

    // Reference model: one operation in flight, completing after its latency.
    logic        m_busy;
    logic        m_done;
    logic        m_dz;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left;
    res_t        pend;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dz   <= pend.dz;
                    if (!pend.dz) begin
                        m_hi <= pend.hi;
                        m_lo <= pend.lo;
                    end
                end
            end else if (start_mult || start_div) begin
                m_busy <= 1'b1;
                pend   <= model_op(!start_mult, rs_val, rt_val);
                m_left <= model_lat(!start_mult, rt_val);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy",     {31'd0, busy},     {31'd0, m_busy});
            chk("cyc_done",     {31'd0, done},     {31'd0, m_done});
            chk("cyc_div_zero", {31'd0, div_zero}, {31'd0, m_dz});
            chk("cyc_hi",       hi_out,            m_hi);
            chk("cyc_lo",       lo_out,            m_lo);
        end
    end

    // Issue one op (caller sits just after an edge) and pin its literal results.
    task automatic run_op(input string name, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int ebusy);
        int n;
        int bcnt;
        start_mult = m;
        start_div  = d;
        rs_val     = a;
        rt_val     = b;
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        rs_val     = $urandom;
        rt_val     = $urandom;
        bcnt = busy ? 1 : 0;
        n    = 61;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
            bcnt += busy ? 1 : 0;
        end
        chk({name, "_latency"}, n, lat);
        chk({name, "_hi"}, hi_out, ehi);
        chk({name, "_lo"}, lo_out, elo);
        chk({name, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        if (ebusy > 0) chk({name, "_busy_cycles"}, bcnt, ebusy);
    endtask

    initial begin
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7_m3",  1, 0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33);
        run_op("mul_min",   1, 0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 0, 33);
        run_op("div_m7_2",  0, 1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
`ifdef MULTDIV_DIVZERO_TRAP_EN
        run_op("div_5_0",   0, 1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1);
`else
        run_op("div_5_0",   0, 1, 32'd5, 32'd0, 34, 32'd5, 32'hFFFF_FFFF, 0, 34);
`endif
        run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 0, 0);
        run_op("div_100_m7", 0, 1, 32'd100, 32'hFFFF_FFF9, 34, 32'd2, 32'hFFFF_FFF2, 0, 0);
        run_op("div_m100_m7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'hFFFF_FFFE, 32'd14, 0, 0);
        run_op("both_starts", 1, 1, 32'd6, 32'd7, 33, 32'h0, 32'd42, 0, 0);
        run_op("mul_m1_m1",  1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0, 32'd1, 0, 0);

        // A divide request arriving mid-multiply is dropped.
        start_mult = 1'b1;
        rs_val     = 32'd7;
        rt_val     = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start_div = 1'b1;
        rs_val    = 32'd100;
        rt_val    = 32'd3;
        @(posedge clk); #1;
        start_div = 1'b0;
        begin
            int n;
            n = 0;
            for (int i = 1; i <= 40; i++) begin
                if (done) begin
                    n = i;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("ignored_div_done_seen", {31'd0, (n != 0)}, 32'd1);
        end
        chk("ignored_div_hi", hi_out, 32'hFFFF_FFFF);
        chk("ignored_div_lo", lo_out, 32'hFFFF_FFEB);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a multiply.
        start_mult = 1'b1;
        rs_val     = 32'd3;
        rt_val     = 32'd5;
        @(posedge clk); #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_op("mul_after_reset", 1, 0, 32'd3, 32'd5, 33, 32'h0, 32'd15, 0, 33);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
